// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: two requesters share one register-file write port.
// Grants are round-robin. The winning write is registered into a write stage,
// and the in-flight write is forwarded to both read ports.
module reg_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_waddr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_waddr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              reg_wen,
    output logic [ADDR_W-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              fwd1_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd2_data
);

    // rr_last_q holds the index of the most recent winner; 1 at reset so port 0 wins the first tie
    logic              rr_last_q, rr_last_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              grant0_c, grant1_c;
    logic              xfer_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_data_c;

    // Round-robin grant; stall suppresses all grants
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (!wb_stall) begin
            if (req0_valid && req1_valid) begin
                if (rr_last_q) grant0_c = 1'b1;
                else           grant1_c = 1'b1;
            end else if (req0_valid) begin
                grant0_c = 1'b1;
            end else if (req1_valid) begin
                grant1_c = 1'b1;
            end
        end
    end

    assign req0_ready = grant0_c;
    assign req1_ready = grant1_c;

    // Winning payload mux and next-state for the write stage and round-robin pointer
    always_comb begin
        xfer_c     = (req0_valid && grant0_c) || (req1_valid && grant1_c);
        sel_addr_c = grant1_c ? req1_waddr : req0_waddr;
        sel_data_c = grant1_c ? req1_wdata : req0_wdata;
        rr_last_d  = rr_last_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (xfer_c) begin
            rr_last_d = grant1_c;
            // x0 writes are accepted but never reach the register file
            wen_d     = (sel_addr_c != ADDR_W'(0));
            waddr_d   = sel_addr_c;
            wdata_d   = sel_data_c;
        end
    end

    // Write stage and round-robin state; reset clears asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign reg_wen   = wen_q;
    assign reg_waddr = waddr_q;
    assign reg_wdata = wdata_q;

    // Forward the in-flight write to the read ports; x0 is never forwarded
    always_comb begin
        fwd1_hit  = wen_q && (waddr_q == rd1_addr) && (rd1_addr != ADDR_W'(0));
        fwd2_hit  = wen_q && (waddr_q == rd2_addr) && (rd2_addr != ADDR_W'(0));
        fwd1_data = wdata_q;
        fwd2_data = wdata_q;
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: vector table plus hand-written reset/round-robin sequence.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_stall;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_waddr, req1_waddr;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready;
    logic        reg_wen;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [4:0]  rd1_addr, rd2_addr;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;

    int checks   = 0;
    int failures = 0;

    reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
        .req0_valid(req0_valid), .req0_waddr(req0_waddr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_waddr(req1_waddr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        e_r0;
        logic        e_r1;
        logic        e_wen;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_h1;
        logic [31:0] e_f1;
        logic        e_h2;
        logic [31:0] e_f2;
    } vec_t;

    function automatic vec_t mk(
        input logic stall, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
        input logic [4:0] rd1, input logic [4:0] rd2,
        input logic r0, input logic r1, input logic wen, input logic [4:0] wa, input logic [31:0] wd,
        input logic h1, input logic [31:0] f1, input logic h2, input logic [31:0] f2);
        vec_t v;
        v.stall = stall; v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1; v.rd1 = rd1; v.rd2 = rd2;
        v.e_r0 = r0; v.e_r1 = r1; v.e_wen = wen; v.e_wa = wa; v.e_wd = wd;
        v.e_h1 = h1; v.e_f1 = f1; v.e_h2 = h2; v.e_f2 = f2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic stall, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] r1, input logic [4:0] r2);
        wb_stall = stall;
        req0_valid = v0; req0_waddr = a0; req0_wdata = d0;
        req1_valid = v1; req1_waddr = a1; req1_wdata = d1;
        rd1_addr = r1; rd2_addr = r2;
    endtask

    // Stimulus-side handshake rule: a pending request must hold valid and payload until accepted
    logic        pv0, pr0, pv1, pr1;
    logic [4:0]  pa0, pa1;
    logic [31:0] pd0, pd1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv0 <= 1'b0; pr0 <= 1'b0; pv1 <= 1'b0; pr1 <= 1'b0;
            pa0 <= '0; pa1 <= '0; pd0 <= '0; pd1 <= '0;
        end else begin
            if (pv0 && !pr0)
                assert (req0_valid && req0_waddr == pa0 && req0_wdata == pd0)
                else $error("handshake rule broken on port 0");
            if (pv1 && !pr1)
                assert (req1_valid && req1_waddr == pa1 && req1_wdata == pd1)
                else $error("handshake rule broken on port 1");
            pv0 <= req0_valid; pr0 <= req0_ready; pa0 <= req0_waddr; pd0 <= req0_wdata;
            pv1 <= req1_valid; pr1 <= req1_ready; pa1 <= req1_waddr; pd1 <= req1_wdata;
        end
    end

    vec_t vecs[$];

    initial begin
        logic [4:0]  p0a, p1a, last_a;
        logic [31:0] p0d, p1d;
        int          g;

        // stall, v0,a0,d0, v1,a1,d1, rd1,rd2, r0,r1, wen,wa,wd, h1,f1,h2,f2
        vecs.push_back(mk(0, 0,0,0,            0,0,0,       0,0, 0,0, 0,0,0,             0,0,0,0));
        vecs.push_back(mk(0, 1,5,32'hDEADBEEF, 0,0,0,       0,0, 1,0, 0,0,0,             0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,            0,0,0,       5,0, 0,0, 1,5,32'hDEADBEEF,  1,32'hDEADBEEF,0,0));
        vecs.push_back(mk(0, 0,0,0,            0,0,0,       5,0, 0,0, 0,5,32'hDEADBEEF,  0,0,0,0));
        vecs.push_back(mk(0, 1,1,32'h11,       1,2,32'h22,  0,0, 0,1, 0,5,32'hDEADBEEF,  0,0,0,0));
        vecs.push_back(mk(0, 1,1,32'h11,       1,3,32'h33,  0,2, 1,0, 1,2,32'h22,        0,0,1,32'h22));
        vecs.push_back(mk(0, 1,4,32'h44,       1,3,32'h33,  0,0, 0,1, 1,1,32'h11,        0,0,0,0));
        vecs.push_back(mk(0, 1,4,32'h44,       0,0,0,       0,0, 1,0, 1,3,32'h33,        0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,            0,0,0,       0,0, 0,0, 1,4,32'h44,        0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,            0,0,0,       4,0, 0,0, 0,4,32'h44,        0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,            1,0,32'h1234,0,0, 0,1, 0,4,32'h44,        0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,            0,0,0,       0,0, 0,0, 0,0,32'h1234,      0,0,0,0));
        vecs.push_back(mk(0, 1,6,32'h66,       1,8,32'h88,  0,0, 1,0, 0,0,32'h1234,      0,0,0,0));
        vecs.push_back(mk(0, 0,0,0,            1,8,32'h88,  6,0, 0,1, 1,6,32'h66,        1,32'h66,0,0));
        vecs.push_back(mk(0, 1,7,32'hA5A50001, 0,0,0,       8,8, 1,0, 1,8,32'h88,        1,32'h88,1,32'h88));
        vecs.push_back(mk(0, 0,0,0,            0,0,0,       7,0, 0,0, 1,7,32'hA5A50001,  1,32'hA5A50001,0,0));
        vecs.push_back(mk(0, 0,0,0,            0,0,0,       7,7, 0,0, 0,7,32'hA5A50001,  0,0,0,0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 1,9,32'h99,   1,10,32'h100,0,0, 0,0, 0,7,32'hA5A50001,  0,0,0,0));
        vecs.push_back(mk(0, 1,9,32'h99,       1,10,32'h100,0,0, 0,1, 0,7,32'hA5A50001,  0,0,0,0));
        vecs.push_back(mk(0, 1,9,32'h99,       0,0,0,       0,0, 1,0, 1,10,32'h100,      0,0,0,0));
        vecs.push_back(mk(1, 0,0,0,            0,0,0,       9,0, 0,0, 1,9,32'h99,        1,32'h99,0,0));

        rst_n = 1'b0;
        drive(0, 0,0,0, 0,0,0, 0,0);
        #3;
        chk("reset_wen",   32'(reg_wen),   32'h0);
        chk("reset_waddr", 32'(reg_waddr), 32'h0);
        chk("reset_wdata", reg_wdata,      32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i].stall, vecs[i].v0, vecs[i].a0, vecs[i].d0,
                     vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].rd1, vecs[i].rd2);
            #1;
            chk($sformatf("v%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].e_r0));
            chk($sformatf("v%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].e_r1));
            chk($sformatf("v%0d_wen", i),    32'(reg_wen),    32'(vecs[i].e_wen));
            chk($sformatf("v%0d_waddr", i),  32'(reg_waddr),  32'(vecs[i].e_wa));
            chk($sformatf("v%0d_wdata", i),  reg_wdata,       vecs[i].e_wd);
            chk($sformatf("v%0d_fwd1_hit", i), 32'(fwd1_hit), 32'(vecs[i].e_h1));
            chk($sformatf("v%0d_fwd2_hit", i), 32'(fwd2_hit), 32'(vecs[i].e_h2));
            if (vecs[i].e_h1) chk($sformatf("v%0d_fwd1_data", i), fwd1_data, vecs[i].e_f1);
            if (vecs[i].e_h2) chk($sformatf("v%0d_fwd2_data", i), fwd2_data, vecs[i].e_f2);
        end

        // Asynchronous reset in mid-cycle while a write is in flight
        @(posedge clk);
        #1 drive(0, 1,12,32'hC0, 0,0,0, 0,0);
        @(posedge clk);
        #1 drive(0, 0,0,0, 0,0,0, 0,0);
        #1 chk("pre_rst_wen", 32'(reg_wen), 32'h1);
        chk("pre_rst_waddr", 32'(reg_waddr), 32'd12);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_wen",   32'(reg_wen),   32'h0);
        chk("async_rst_waddr", 32'(reg_waddr), 32'h0);
        chk("async_rst_wdata", reg_wdata,      32'h0);
        #1 rst_n = 1'b1;

        // Post-reset ties alternate 0,1,0,1 with full throughput
        p0a = 5'd11; p0d = 32'hB000; p1a = 5'd21; p1d = 32'hC000; last_a = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 drive(0, 1,p0a,p0d, 1,p1a,p1d, 0,0);
            #1;
            g = i % 2;
            chk($sformatf("rr%0d_ready0", i), 32'(req0_ready), 32'(g == 0));
            chk($sformatf("rr%0d_ready1", i), 32'(req1_ready), 32'(g == 1));
            chk($sformatf("rr%0d_wen", i), 32'(reg_wen), 32'(i > 0));
            if (i > 0) chk($sformatf("rr%0d_waddr", i), 32'(reg_waddr), 32'(last_a));
            if (g == 0) begin
                last_a = p0a; p0a = p0a + 5'd1; p0d = p0d + 32'd1;
            end else begin
                last_a = p1a; p1a = p1a + 5'd1; p1d = p1d + 32'd1;
            end
        end
        @(posedge clk);
        #1 drive(0, 1,p0a,p0d, 0,0,0, 0,0);
        #1 chk("rr_tail_ready0", 32'(req0_ready), 32'h1);
        chk("rr_tail_wen",   32'(reg_wen),   32'h1);
        chk("rr_tail_waddr", 32'(reg_waddr), 32'(last_a));
        last_a = p0a;
        @(posedge clk);
        #1 drive(0, 0,0,0, 0,0,0, 0,0);
        #1 chk("rr_last_wen", 32'(reg_wen),   32'h1);
        chk("rr_last_waddr",  32'(reg_waddr), 32'(last_a));
        chk("rr_last_wdata",  reg_wdata,      p0d);
        @(posedge clk);
        #2 chk("rr_idle_wen", 32'(reg_wen), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
